// File: rtl/bp_pkg.sv
// Shared types and geometry for the BTB/GHR front-end predictor stage.
package bp_pkg;

  localparam int unsigned GHR_W       = 8;
  localparam int unsigned BTB_ENTRIES = 64;
  localparam int unsigned IDX_W       = 6;
  localparam int unsigned TAG_W       = 32 - IDX_W - 2;

  typedef enum logic {
    BR_COND = 1'b0,
    BR_JUMP = 1'b1
  } br_type_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic             is_jump;
    logic             bias;
  } btb_entry_t;

  function automatic logic [IDX_W-1:0] pc_idx(input logic [31:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
    return pc[31:IDX_W+2];
  endfunction

endpackage

// File: rtl/ghr_reg.sv
// Speculative global history register with execute-stage repair on mispredict.
module ghr_reg
  import bp_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_fetch_shift,
  input  logic             i_pred_taken,
  input  logic             i_upd_valid,
  input  logic             i_upd_mispredict,
  input  logic             i_upd_is_branch,
  input  logic             i_upd_is_jump,
  input  logic             i_upd_taken,
  input  logic [GHR_W-1:0] i_upd_ghr,
  output logic [GHR_W-1:0] o_ghr
);

  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_d;
  logic             recover;

  assign recover = i_upd_valid && i_upd_mispredict;

  // Recovery outranks the speculative fetch shift issued in the same cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (recover && i_upd_is_branch) begin
      ghr_d = {i_upd_ghr[GHR_W-2:0], i_upd_taken};
    end else if (recover && i_upd_is_jump) begin
      ghr_d = i_upd_ghr;
    end else if (i_fetch_shift) begin
      ghr_d = {ghr_q[GHR_W-2:0], i_pred_taken};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign o_ghr = ghr_q;

endmodule

// File: rtl/btb_bias_ghr.sv
// Direct-mapped BTB with sticky per-entry bias bit, feeding GHR and bias to the agree-PHT.
module btb_bias_ghr
  import bp_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_fetch_valid,
  input  logic [31:0]      i_fetch_pc,
  input  logic             i_pred_taken,
  output logic [GHR_W-1:0] o_ghr,
  output logic             o_btb_hit,
  output logic             o_bias,
  output logic             o_is_branch,
  output logic             o_is_jump,
  output logic [31:0]      o_target,
  input  logic             i_upd_valid,
  input  logic [31:0]      i_upd_pc,
  input  logic [31:0]      i_upd_target,
  input  logic             i_upd_taken,
  input  logic             i_upd_is_branch,
  input  logic             i_upd_is_jump,
  input  logic [GHR_W-1:0] i_upd_ghr,
  input  logic             i_upd_mispredict
);

  btb_entry_t       btb_q [BTB_ENTRIES];
  btb_entry_t       btb_d [BTB_ENTRIES];
  btb_entry_t       fetch_entry;
  btb_entry_t       upd_entry;
  btb_entry_t       new_entry;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             fetch_hit;
  logic             upd_hit;
  logic             upd_en;
  br_type_e         upd_type;
  logic [3:0]       unused_pc_lsbs;

  assign unused_pc_lsbs = {i_fetch_pc[1:0], i_upd_pc[1:0]};

  assign fetch_idx   = pc_idx(i_fetch_pc);
  assign fetch_entry = btb_q[fetch_idx];
  assign fetch_hit   = fetch_entry.valid && (fetch_entry.tag == pc_tag(i_fetch_pc));

  assign o_btb_hit   = fetch_hit;
  assign o_bias      = fetch_hit && fetch_entry.bias;
  assign o_is_jump   = fetch_hit && fetch_entry.is_jump;
  assign o_is_branch = fetch_hit && !fetch_entry.is_jump;
  assign o_target    = fetch_hit ? fetch_entry.target : 32'h0;

  assign upd_idx   = pc_idx(i_upd_pc);
  assign upd_entry = btb_q[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == pc_tag(i_upd_pc));
  assign upd_en    = i_upd_valid && (i_upd_is_branch || i_upd_is_jump);
  assign upd_type  = i_upd_is_jump ? BR_JUMP : BR_COND;

  // Bias is captured only on allocation and stays fixed while the entry lives.
  always_comb begin
    new_entry         = upd_entry;
    new_entry.valid   = 1'b1;
    new_entry.tag     = pc_tag(i_upd_pc);
    new_entry.target  = i_upd_target;
    new_entry.is_jump = (upd_type == BR_JUMP);
    new_entry.bias    = upd_hit ? upd_entry.bias : i_upd_taken;
  end

  always_comb begin
    btb_d = btb_q;
    if (upd_en) begin
      btb_d[upd_idx] = new_entry;
    end
  end

  // Only valid bits need reset; payload fields are don't-care until allocated.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        btb_q[i].valid <= 1'b0;
      end
    end else begin
      btb_q <= btb_d;
    end
  end

  ghr_reg u_ghr_reg (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_fetch_shift   (i_fetch_valid && o_is_branch),
    .i_pred_taken    (i_pred_taken),
    .i_upd_valid     (i_upd_valid),
    .i_upd_mispredict(i_upd_mispredict),
    .i_upd_is_branch (i_upd_is_branch),
    .i_upd_is_jump   (i_upd_is_jump),
    .i_upd_taken     (i_upd_taken),
    .i_upd_ghr       (i_upd_ghr),
    .o_ghr           (o_ghr)
  );

endmodule

// File: tb/tb_btb_bias_ghr.sv
// Directed bench for btb_bias_ghr: BTB allocation, sticky bias, GHR shift and recovery, reset.
module tb_btb_bias_ghr;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [7:0]  ghr;
  logic        btb_hit;
  logic        bias;
  logic        is_branch;
  logic        is_jump;
  logic [31:0] target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_is_branch;
  logic        upd_is_jump;
  logic [7:0]  upd_ghr;
  logic        upd_mispredict;

  int n_checks = 0;
  int n_errors = 0;

  btb_bias_ghr dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_fetch_valid   (fetch_valid),
    .i_fetch_pc      (fetch_pc),
    .i_pred_taken    (pred_taken),
    .o_ghr           (ghr),
    .o_btb_hit       (btb_hit),
    .o_bias          (bias),
    .o_is_branch     (is_branch),
    .o_is_jump       (is_jump),
    .o_target        (target),
    .i_upd_valid     (upd_valid),
    .i_upd_pc        (upd_pc),
    .i_upd_target    (upd_target),
    .i_upd_taken     (upd_taken),
    .i_upd_is_branch (upd_is_branch),
    .i_upd_is_jump   (upd_is_jump),
    .i_upd_ghr       (upd_ghr),
    .i_upd_mispredict(upd_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                     input logic br, input logic jmp, input logic [7:0] g, input logic misp);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_target     = tgt;
    upd_taken      = taken;
    upd_is_branch  = br;
    upd_is_jump    = jmp;
    upd_ghr        = g;
    upd_mispredict = misp;
  endtask

  task automatic no_upd();
    upd_valid      = 1'b0;
    upd_is_branch  = 1'b0;
    upd_is_jump    = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic v, input logic pt);
    fetch_pc    = pc;
    fetch_valid = v;
    pred_taken  = pt;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    fetch_valid = 1'b0; fetch_pc = '0; pred_taken = 1'b0;
    upd_pc = '0; upd_target = '0; upd_taken = 1'b0; upd_ghr = '0;
    no_upd();
    tick(); tick();
    check("rst_ghr", 32'(ghr), 32'h0);
    check("rst_hit", 32'(btb_hit), 32'h0);
    rst = 1'b0;
    tick();

    // Allocate a not-taken branch; same-cycle lookup still sees the old contents.
    upd(32'h0000_1040, 32'h0000_1100, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    fetch(32'h0000_1040, 1'b0, 1'b0);
    check("rbw_hit", 32'(btb_hit), 32'h0);
    tick(); no_upd(); fetch(32'h0000_1040, 1'b0, 1'b0);
    check("alloc_hit", 32'(btb_hit), 32'h1);
    check("alloc_isbr", 32'(is_branch), 32'h1);
    check("alloc_isjmp", 32'(is_jump), 32'h0);
    check("alloc_bias", 32'(bias), 32'h0);
    check("alloc_tgt", target, 32'h0000_1100);
    check("alloc_ghr", 32'(ghr), 32'h0);

    // Refresh with taken=1: bias is sticky.
    upd(32'h0000_1040, 32'h0000_1100, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(); no_upd(); fetch(32'h0000_1040, 1'b0, 1'b0);
    check("sticky_bias", 32'(bias), 32'h0);

    // Same index, new tag: replace with bias=1.
    upd(32'h0001_1040, 32'h0000_2200, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    tick(); no_upd(); fetch(32'h0000_1040, 1'b0, 1'b0);
    check("old_tag_hit", 32'(btb_hit), 32'h0);
    check("miss_tgt", target, 32'h0);
    check("miss_bias", 32'(bias), 32'h0);
    fetch(32'h0001_1040, 1'b0, 1'b0);
    check("new_tag_hit", 32'(btb_hit), 32'h1);
    check("new_tag_bias", 32'(bias), 32'h1);
    check("new_tag_tgt", target, 32'h0000_2200);

    // Jump mispredict loads GHR=0x5A and allocates a jump entry.
    upd(32'h0000_3000, 32'h0000_4000, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1);
    tick(); no_upd(); fetch(32'h0000_3000, 1'b0, 1'b0);
    check("jmp_ghr", 32'(ghr), 32'h5A);
    check("jmp_hit", 32'(btb_hit), 32'h1);
    check("jmp_isjmp", 32'(is_jump), 32'h1);
    check("jmp_isbr", 32'(is_branch), 32'h0);
    check("jmp_bias", 32'(bias), 32'h1);

    // Speculative shifts on fetch of a hitting branch.
    fetch(32'h0001_1040, 1'b1, 1'b1);
    tick();
    check("shift_t", 32'(ghr), 32'hB5);
    fetch(32'h0001_1040, 1'b1, 1'b0);
    tick();
    check("shift_nt", 32'(ghr), 32'h6A);
    fetch(32'h0000_3000, 1'b1, 1'b1);
    tick();
    check("jmp_noshift", 32'(ghr), 32'h6A);
    fetch(32'h0001_1040, 1'b0, 1'b1);
    tick();
    check("invalid_noshift", 32'(ghr), 32'h6A);
    fetch(32'h0000_9000, 1'b1, 1'b1);
    tick();
    check("miss_noshift", 32'(ghr), 32'h6A);

    // Recovery beats a same-cycle fetch shift.
    fetch(32'h0001_1040, 1'b1, 1'b1);
    upd(32'h0001_1040, 32'h0000_2200, 1'b0, 1'b1, 1'b0, 8'h0F, 1'b1);
    tick(); no_upd(); fetch(32'h0001_1040, 1'b0, 1'b0);
    check("recover_ghr", 32'(ghr), 32'h1E);
    check("recover_bias", 32'(bias), 32'h1);

    // Jump mispredict with a fresh entry.
    upd(32'h0000_5004, 32'h0000_6000, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1);
    tick(); no_upd(); fetch(32'h0000_5004, 1'b0, 1'b0);
    check("jmp2_ghr", 32'(ghr), 32'h33);
    check("jmp2_isjmp", 32'(is_jump), 32'h1);
    check("jmp2_bias", 32'(bias), 32'h1);
    check("jmp2_tgt", target, 32'h0000_6000);

    // Non-control update touches neither BTB nor GHR.
    upd(32'h0000_6008, 32'h0000_7000, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b1);
    tick(); no_upd(); fetch(32'h0000_6008, 1'b0, 1'b0);
    check("nonctl_ghr", 32'(ghr), 32'h33);
    check("nonctl_hit", 32'(btb_hit), 32'h0);

    // Both type flags set: stored as a jump.
    upd(32'h0000_7010, 32'h0000_8000, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    tick(); no_upd(); fetch(32'h0000_7010, 1'b0, 1'b0);
    check("both_isjmp", 32'(is_jump), 32'h1);
    check("both_isbr", 32'(is_branch), 32'h0);

    // Async reset asserted mid-update.
    fetch(32'h0000_3000, 1'b0, 1'b0);
    upd(32'h0000_8020, 32'h0000_9000, 1'b1, 1'b1, 1'b0, 8'h77, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_ghr", 32'(ghr), 32'h0);
    check("arst_hit", 32'(btb_hit), 32'h0);
    tick();
    rst = 1'b0;
    no_upd();
    tick();
    fetch(32'h0000_8020, 1'b0, 1'b0);
    check("arst_upd_miss", 32'(btb_hit), 32'h0);
    check("arst_ghr_after", 32'(ghr), 32'h0);
    fetch(32'h0000_3000, 1'b0, 1'b0);
    check("arst_old_miss", 32'(btb_hit), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/btb_bias_ghr.md
Name: btb_bias_ghr

Overview:
- Front-end predictor stage directly upstream of the agree-PHT.
- Supplies, each fetch cycle, the global history (o_ghr), the per-branch bias bit (o_bias), the branch/jump classification and the predicted target from a direct-mapped BTB.
- Maintains the GHR speculatively at fetch and repairs it from the execute-stage snapshot on a mispredict.
- Installs and refreshes BTB entries, including the bias bit, from resolved branches.

Parameters:
- GHR_W, 8: global history width; must match the PHT history input.
- BTB_ENTRIES, 64: number of BTB entries, direct-mapped.
- IDX_W, 6: log2(BTB_ENTRIES). Index is PC[IDX_W+1:2]; tag is PC[31:IDX_W+2], 24 bits at default.

Ports:
- i_clk, in, 1: clock, rising edge.
- i_rst, in, 1: asynchronous, active-high reset.
- i_fetch_valid, in, 1: fetch PC valid this cycle.
- i_fetch_pc, in, 32: fetch PC.
- i_pred_taken, in, 1: PHT prediction for the current fetch PC, used for the speculative GHR shift.
- o_ghr, out, GHR_W: current speculative history; the pipeline carries it with the instruction.
- o_btb_hit, out, 1: valid entry with matching tag.
- o_bias, out, 1: bias bit of the hit entry; 0 on miss.
- o_is_branch, out, 1: hit entry is a conditional branch.
- o_is_jump, out, 1: hit entry is an unconditional jump.
- o_target, out, 32: predicted target; 0 on miss.
- i_upd_valid, in, 1: resolved control-transfer instruction from execute.
- i_upd_pc, in, 32: PC of the resolved instruction.
- i_upd_target, in, 32: computed target, supplied whether or not the branch was taken.
- i_upd_taken, in, 1: actual outcome; 1 for jumps.
- i_upd_is_branch, in, 1: conditional branch.
- i_upd_is_jump, in, 1: jal/jalr.
- i_upd_ghr, in, GHR_W: o_ghr snapshot carried with this instruction.
- i_upd_mispredict, in, 1: direction or target was mispredicted.

Behaviour:
- Reset (async, any time, including mid-update):
  - GHR = 0; all BTB valid bits = 0.
  - Consequently o_btb_hit, o_bias, o_is_branch, o_is_jump, o_target and o_ghr are all 0.
  - Tag, target and bias storage need no reset.
- Lookup (combinational from registered state, zero latency):
  - Hit = valid[idx] && tag[idx] == fetch tag.
  - On miss, all entry outputs are 0.
  - Lookup is independent of i_fetch_valid; only GHR update is gated by it.
- GHR next-state, priority order:
  1. i_upd_valid && i_upd_mispredict && i_upd_is_branch: GHR <= {i_upd_ghr[GHR_W-2:0], i_upd_taken}.
  2. i_upd_valid && i_upd_mispredict && i_upd_is_jump: GHR <= i_upd_ghr. Jumps never shift history.
  3. i_fetch_valid && o_btb_hit && o_is_branch: GHR <= {GHR[GHR_W-2:0], i_pred_taken}.
  4. Otherwise hold.
  - A recovery and a fetch shift in the same cycle: recovery wins; the fetch shift is discarded.
- BTB update, on i_upd_valid && (i_upd_is_branch || i_upd_is_jump):
  - Existing entry (valid, tag match):
    - Write target and type.
    - Bias is unchanged; it is sticky for the life of the entry.
  - Miss or tag conflict (allocate/replace):
    - valid = 1; tag, target and type written.
    - Bias = i_upd_taken; jumps therefore always get bias 1.
  - If i_upd_is_branch and i_upd_is_jump are both set, the entry is treated as a jump.
  - Non-control updates (both type flags 0) are ignored for the BTB and GHR.
- Same-index lookup and update in one cycle:
  - Lookup returns the pre-update contents (read-before-write).
  - The new contents are visible next cycle.
- The GHR shift is wrap-free: the oldest bit is dropped.

Decomposition:
- Shared package bp_pkg holds:
  - GHR_W and BTB index/tag width constants.
  - btb_entry_t struct {valid, tag, target, is_jump, bias}.
  - br_type_e enum {BR_COND, BR_JUMP}.
- Sub-module ghr_reg holds the GHR priority/shift logic; the BTB array stays in the top module.

Test Plan:
- Reset asserted mid-update (i_upd_valid=1) -> same cycle o_ghr=0 and o_btb_hit=0; after release, a lookup of the updated PC misses.
- Update branch pc=0x0000_1040, target=0x0000_1100, taken=0 -> next cycle fetch 0x1040 gives hit=1, is_branch=1, bias=0, target=0x1100.
- Same entry updated again with taken=1 -> bias stays 0; then update pc=0x0001_1040 (same index, new tag) taken=1 -> 0x1040 misses, 0x11040 hits with bias=1.
- GHR=0x5A, fetch hits a branch with pred_taken=1 -> GHR=0xB5; repeat with pred_taken=0 -> GHR=0x6A.
- Same cycle: fetch shift plus branch mispredict with upd_ghr=0x0F, taken=0 -> GHR=0x1E (recovery wins).
- Jump mispredict with upd_ghr=0x33 -> GHR=0x33; the jump entry is allocated with bias=1 and is_jump=1.
